// File: rtl/tiled_matvec_pkg.sv
// rtl/tiled_matvec_pkg.sv - shared FSM state type and tile-count helpers for tiled_matvec
// Contents:
//   state_t    : IDLE / RUN / DONE controller states
//   tile_count : number of B x B tiles in a W x W matrix
//   cnt_width  : tile counter width (at least 1 bit)
package tiled_matvec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int tile_count(input int w, input int b);
    return (w / b) * (w / b);
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/tiled_matvec_tile_reduce.sv
// rtl/tiled_matvec_tile_reduce.sv - combinational B x B tile times B-bit vector slice reduction
// Ports:
//   tile : B*B bits, row-major within the tile (tile[r*B+c] = tile row r, column c)
//   xs   : B-bit slice of the operand vector matching the tile columns
//   mode : 0 = XOR reduction, 1 = OR reduction
//   red  : B reduced bits, one per tile row
module tile_reduce #(
  parameter int B = 4
) (
  input  logic [B*B-1:0] tile,
  input  logic [B-1:0]   xs,
  input  logic           mode,
  output logic [B-1:0]   red
);

  always_comb begin
    red = '0;
    for (int r = 0; r < B; r++) begin
      red[r] = mode ? |(tile[r*B +: B] & xs) : ^(tile[r*B +: B] & xs);
    end
  end

endmodule

// File: rtl/tiled_matvec.sv
// rtl/tiled_matvec.sv - tiled W x W Boolean/GF(2) matrix-vector multiplier, one tile per cycle
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : begin one multiply (ignored while busy)
//   mode  : 0 = XOR reduction, 1 = OR reduction, sampled with start
//   x     : W-bit operand vector
//   A     : W*W-bit matrix, row-major (A[i*W+j] = row i, column j)
//   busy  : high while tiles are being processed
//   done  : one-cycle pulse when y is updated
//   y     : registered result, held until the next completion or reset
module tiled_matvec
  import tiled_matvec_pkg::*;
#(
  parameter int W = 16,
  parameter int B = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [W-1:0]   x,
  input  logic [W*W-1:0] A,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   y
);

  localparam int NT = W / B;
  localparam int T  = tile_count(W, B);
  localparam int CW = cnt_width(T);

  generate
    if (W % B != 0) begin : g_bad_tiling
      $error("tiled_matvec: W must be a multiple of B");
    end
  endgenerate

  state_t         state, state_n;
  logic [W*W-1:0] a_q;
  logic [W-1:0]   x_q;
  logic           mode_q;
  logic [W-1:0]   acc, acc_n;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           accept;
  int             ii, jj;
  logic [B*B-1:0] tile;
  logic [B-1:0]   xs;
  logic [B-1:0]   red;

  assign last   = (cnt == CW'(T - 1));
  assign accept = start && (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Tile select: counter runs row-tile outer, column-tile inner. Shifting the
  // captured operands keeps the slice muxes free of wide variable bit-selects.
  always_comb begin
    ii   = int'(cnt) / NT;
    jj   = int'(cnt) % NT;
    xs   = B'(x_q >> (jj * B));
    tile = '0;
    for (int r = 0; r < B; r++) begin
      tile[r*B +: B] = B'(a_q >> ((ii * B + r) * W + jj * B));
    end
  end

  tile_reduce #(.B(B)) u_reduce (
    .tile (tile),
    .xs   (xs),
    .mode (mode_q),
    .red  (red)
  );

  // Fold the tile's partial results into the accumulator rows of row-tile ii.
  always_comb begin
    acc_n = acc;
    for (int i = 0; i < W; i++) begin
      if (i / B == ii) begin
        acc_n[i] = mode_q ? (acc[i] | red[i % B]) : (acc[i] ^ red[i % B]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      x_q    <= '0;
      mode_q <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      y      <= '0;
    end else if (accept) begin
      a_q    <= A;
      x_q    <= x;
      mode_q <= mode;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc <= acc_n;
      // The last tile's fold goes straight to y; the counter parks on T-1.
      if (last) y   <= acc_n;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: doc/tiled_matvec.md
TILED_MATVEC -- requirements
Module: tiled_matvec

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the vector length and the matrix dimension (W x W).
REQ-002 The block SHALL have parameter B, default 4, giving the tile edge; W mod B != 0 SHALL be an elaboration error.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin one multiply.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = GF(2) reduction (XOR), 1 = Boolean reduction (OR); it is sampled with start.
REQ-007 The block SHALL have port x, input, W bits, the operand vector.
REQ-008 The block SHALL have port A, input, W*W bits, row-major; A[i*W+j] = row i, column j.
REQ-009 The block SHALL have port busy, output, 1 bit, high while tiles are being processed.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse when y becomes valid.
REQ-011 The block SHALL have port y, output, W bits, the registered result.

Function
REQ-012 Result SHALL be y[i] = reduce over j of (A[i*W+j] & x[j]), where reduce is XOR (mode 0) or OR (mode 1).
REQ-013 FSM states SHALL be IDLE, RUN and DONE; reset state IDLE.
REQ-014 In IDLE or DONE with start=1, the block SHALL capture A, x and mode into internal registers, clear the accumulator, set the tile counter to 0, and enter RUN.
REQ-015 In RUN, the block SHALL process one B x B tile per cycle in raster order: row-tile ii outer, column-tile jj inner, T = (W/B)^2 tiles in total.
REQ-016 For each tile, the block SHALL fold the B partial reductions into acc[ii*B .. ii*B+B-1] using the captured mode.
REQ-017 On the edge that processes tile T-1, the block SHALL load y from the accumulator, pulse done for exactly one cycle, drop busy, and enter DONE.
REQ-018 Latency: done SHALL be high in the cycle that begins T edges after the start-accepting edge (W=16, B=4: 16 cycles).
REQ-019 busy SHALL be 1 exactly in RUN.
REQ-020 y SHALL hold its value from REQ-017 until the next completion or reset.
REQ-021 In DONE without start, the block SHALL return to IDLE on the next edge.
REQ-022 start while busy SHALL be ignored, and the captured operands SHALL be unaffected.
REQ-023 start in the done cycle SHALL be accepted: back-to-back operation, with the previous y held until the new completion.
REQ-024 Changes on A, x or mode after capture SHALL NOT affect the running result.
REQ-025 With B = W, T = 1, and done SHALL assert one cycle after start is accepted.
REQ-026 The tile counter SHALL be clog2(T) bits wide (minimum 1) and SHALL NOT wrap within a run.

Reset
REQ-027 rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, y=0, accumulator=0 and tile counter=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the operation with no done pulse.
REQ-029 After reset deasserts, the first start SHALL behave as from power-up.

Structure
REQ-030 Package tiled_matvec_pkg SHALL hold the FSM state enum and a function computing T from W and B.
REQ-031 Sub-module tile_reduce (combinational) SHALL take a B x B tile, a B-bit x slice and mode, and produce B reduced bits.
REQ-032 The top level SHALL hold the FSM, operand registers, accumulator and tile-slice muxing.

Verification (W=16, B=4 unless noted)
REQ-033 Identity A, x=16'hA5C3, mode 0, start -> y=16'hA5C3, done exactly 16 cycles after start, busy high for 16 cycles.
REQ-034 All-ones A, x=16'h0003 -> mode 0 gives y=16'h0000; mode 1 gives y=16'hFFFF; x=16'h0007 with mode 0 gives y=16'hFFFF.
REQ-035 Identity A with x=16'h1234, then start re-pulsed at cycle 5 with x=16'hFFFF -> result y=16'h1234, single done at cycle 16.
REQ-036 rst pulsed at tile 7 -> y=0, busy=0, no done; a new start with identity A and x=16'h00FF -> y=16'h00FF after 16 cycles.
REQ-037 start held high across the done cycle with new x=16'h8001 (identity A) -> second done 16 cycles later with y=16'h8001; prior y stable until then.
REQ-038 With B=16 and the REQ-033 stimulus -> y=16'hA5C3, done one cycle after start.
